// File: rtl/cbus_reset_sequencer.sv
// cbus clock-group member reset/clock-enable sequencer with re-reset support.
// Optional status outputs are enabled by defining CBUS_RST_SEQ_STATUS_EN.
module cbus_reset_sequencer #(
    parameter int SYNC_STAGES    = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int CNT_W          = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_sw_reset_req,
    input  logic       io_ext_hold,
    output logic       io_out_reset,
    output logic       io_clock_en,
    output logic       io_sw_reset_ack,
    output logic [2:0] io_state
`ifdef CBUS_RST_SEQ_STATUS_EN
    ,
    output logic [7:0] io_reset_count,
    output logic       io_hold_seen
`endif
);

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        GATE   = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYCLES - 1);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   pending, pending_n;
    logic                   req_prev;
    logic                   sync_done;
    logic                   req_edge;
    logic                   restart;
    logic                   enter_run;

    assign sync_done = sync[SYNC_STAGES-1];
    assign req_edge  = io_sw_reset_req & ~req_prev;
    assign restart   = io_ext_hold | req_edge;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            ASSERT: begin
                if (sync_done && !io_ext_hold) begin
                    state_n = HOLD;
                    cnt_n   = STRETCH_LD;
                end
            end
            HOLD: begin
                if (restart) begin
                    cnt_n = STRETCH_LD;
                end else if (cnt == '0) begin
                    state_n = GATE;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GATE: begin
                if (restart) begin
                    state_n = HOLD;
                    cnt_n   = STRETCH_LD;
                end else if (cnt == '0) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RUN: begin
                if (restart) begin
                    state_n = HOLD;
                    cnt_n   = STRETCH_LD;
                end
            end
            default: begin
                state_n = ASSERT;
                cnt_n   = '0;
            end
        endcase
    end

    // Ack and pending clear happen only on the edge that enters RUN.
    always_comb begin
        enter_run = (state_n == RUN) && (state != RUN);
        pending_n = pending;
        if (enter_run) begin
            pending_n = 1'b0;
        end else if (req_edge) begin
            pending_n = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ASSERT;
            cnt             <= '0;
            sync            <= '0;
            pending         <= 1'b0;
            req_prev        <= 1'b0;
            io_out_reset    <= 1'b1;
            io_clock_en     <= 1'b1;
            io_sw_reset_ack <= 1'b0;
            io_state        <= 3'd0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            sync            <= {sync[SYNC_STAGES-2:0], 1'b1};
            pending         <= pending_n;
            req_prev        <= io_sw_reset_req;
            io_out_reset    <= (state_n != RUN);
            io_clock_en     <= (state_n != GATE);
            io_sw_reset_ack <= enter_run & pending;
            io_state        <= {1'b0, state_n};
        end
    end

`ifdef CBUS_RST_SEQ_STATUS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_reset_count <= 8'd0;
            io_hold_seen   <= 1'b0;
        end else begin
            if (enter_run && io_reset_count != 8'hff) begin
                io_reset_count <= io_reset_count + 8'd1;
            end
            if (state == RUN && io_ext_hold) begin
                io_hold_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cbus_reset_sequencer.sv
// Directed, table-driven bench for cbus_reset_sequencer.
// Status-port checks run only when CBUS_RST_SEQ_STATUS_EN is defined.
module tb_cbus_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       io_sw_reset_req;
    logic       io_ext_hold;
    logic       io_out_reset;
    logic       io_clock_en;
    logic       io_sw_reset_ack;
    logic [2:0] io_state;
`ifdef CBUS_RST_SEQ_STATUS_EN
    logic [7:0] io_reset_count;
    logic       io_hold_seen;
`endif

    int checks   = 0;
    int failures = 0;
    int acks     = 0;
    int hold_ent = 0;
    logic [2:0] prev_st = 3'd0;

    cbus_reset_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .io_sw_reset_req (io_sw_reset_req),
        .io_ext_hold     (io_ext_hold),
        .io_out_reset    (io_out_reset),
        .io_clock_en     (io_clock_en),
        .io_sw_reset_ack (io_sw_reset_ack),
        .io_state        (io_state)
`ifdef CBUS_RST_SEQ_STATUS_EN
        ,
        .io_reset_count  (io_reset_count),
        .io_hold_seen    (io_hold_seen)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         gap;
        logic       req;
        logic       hold;
        logic       rst;
        logic       en;
        logic       ack;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clock);
        #1;
        if (io_sw_reset_ack) acks++;
        if (io_state == 3'd1 && prev_st == 3'd3) hold_ent++;
        prev_st = io_state;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int outs();
        return {io_out_reset, io_clock_en, io_sw_reset_ack, io_state};
    endfunction

    function automatic int pack(input logic r, input logic e,
                                input logic a, input logic [2:0] s);
        return {r, e, a, s};
    endfunction

    initial begin
        int base;
        int ab;
        vecs[0]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[1]  = '{2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[2]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        vecs[3]  = '{15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        vecs[4]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[5]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[6]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3};
        vecs[7]  = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3};
        vecs[8]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        vecs[9]  = '{15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        vecs[10] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[11] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        vecs[12] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
        vecs[13] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3};

        reset = 1'b1;
        io_sw_reset_req = 1'b0;
        io_ext_hold = 1'b0;
        steps(3);
        check("reset_outs", outs(), pack(1, 1, 0, 3'd0));
        reset = 1'b0;

        // Power-on release followed by a one-cycle software re-reset.
        for (int i = 0; i < 14; i++) begin
            io_sw_reset_req = vecs[i].req;
            io_ext_hold = vecs[i].hold;
            steps(vecs[i].gap);
            check($sformatf("vec%0d", i), outs(),
                  pack(vecs[i].rst, vecs[i].en, vecs[i].ack, vecs[i].st));
        end

        // Request held high for 40 cycles yields a single sequence.
        base = acks;
        ab = hold_ent;
        io_sw_reset_req = 1'b1;
        steps(40);
        check("held_req_acks", acks - base, 1);
        check("held_req_seqs", hold_ent - ab, 1);
        check("held_req_state", io_state, 3);
        io_sw_reset_req = 1'b0;
        steps(5);
        check("req_fall_noack", acks - base, 1);
        io_sw_reset_req = 1'b1;
        step();
        check("req_rise_retrig", io_state, 1);
        io_sw_reset_req = 1'b0;
        steps(18);
        check("req_rise_ack", {io_sw_reset_ack, io_state}, {1'b1, 3'd3});

        // ext_hold from RUN, then held 10 cycles mid-HOLD.
        base = acks;
        io_ext_hold = 1'b1;
        step();
        check("hold_enter", outs(), pack(1, 1, 0, 3'd1));
        io_ext_hold = 1'b0;
        steps(10);
        io_ext_hold = 1'b1;
        steps(10);
        check("hold_stays", io_state, 1);
        io_ext_hold = 1'b0;
        steps(15);
        check("hold_count15", io_state, 1);
        step();
        check("hold_gate", outs(), pack(1, 0, 0, 3'd2));
        steps(2);
        check("hold_run18", outs(), pack(0, 1, 0, 3'd3));
        check("hold_noack", acks - base, 0);
`ifdef CBUS_RST_SEQ_STATUS_EN
        check("hold_seen_set", io_hold_seen, 1);
`endif

        // Request edge while gating restarts the full stretch.
        base = acks;
        io_ext_hold = 1'b1;
        step();
        io_ext_hold = 1'b0;
        steps(16);
        check("gate_reached", io_state, 2);
        io_sw_reset_req = 1'b1;
        step();
        check("gate_to_hold", outs(), pack(1, 1, 0, 3'd1));
        io_sw_reset_req = 1'b0;
        steps(17);
        check("gate_restretch", io_state, 2);
        step();
        check("gate_run_ack", outs(), pack(0, 1, 1, 3'd3));
        check("gate_ack_cnt", acks - base, 1);

        // Asynchronous reset mid-HOLD with a request pending.
        io_sw_reset_req = 1'b1;
        step();
        io_sw_reset_req = 1'b0;
        steps(4);
        #3 reset = 1'b1;
        #1;
        check("async_reset", outs(), pack(1, 1, 0, 3'd0));
`ifdef CBUS_RST_SEQ_STATUS_EN
        check("rst_hold_seen", io_hold_seen, 0);
        check("rst_count", io_reset_count, 0);
`endif
        step();
        reset = 1'b0;
        base = acks;
        steps(21);
        check("rel_gate", io_state, 2);
        step();
        check("rel_run", outs(), pack(0, 1, 0, 3'd3));
        check("rel_noack", acks - base, 0);

`ifdef CBUS_RST_SEQ_STATUS_EN
        check("count_one", io_reset_count, 1);
        for (int i = 0; i < 300; i++) begin
            io_sw_reset_req = 1'b1;
            step();
            io_sw_reset_req = 1'b0;
            steps(17);
        end
        check("count_sat", io_reset_count, 255);
        check("run_after_loop", io_state, 3);
        check("hold_seen_clear", io_hold_seen, 0);
        io_ext_hold = 1'b1;
        step();
        io_ext_hold = 1'b0;
        steps(3);
        check("hold_seen_sticky", io_hold_seen, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
